// File: rtl/fire_pkg.sv
// Shared definitions for the launcher firing path: controller state encoding and the
// clock/shot-window constants that the PWM sequencer must agree on.
package fire_pkg;

    localparam int unsigned CLK_HZ              = 50000000;
    localparam int unsigned SHOT_CYCLES_DEFAULT = 50000000;

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StShot,
        StCooldown
    } fire_state_e;

endpackage

// File: rtl/fire_request_ctrl_if.sv
// Request/status bundle between the fire request controller and whoever drives it.
interface fire_request_ctrl_if;

    logic       fire_req;
    logic       arm;
    logic       reload;
    logic       shoot_pulse;
    logic       busy;
    logic       ready;
    logic [7:0] shots_left;
    logic       req_dropped;

    modport master (
        output fire_req,
        output arm,
        output reload,
        input  shoot_pulse,
        input  busy,
        input  ready,
        input  shots_left,
        input  req_dropped
    );

    modport slave (
        input  fire_req,
        input  arm,
        input  reload,
        output shoot_pulse,
        output busy,
        output ready,
        output shots_left,
        output req_dropped
    );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a debounce counter; a level change is accepted only
// after the synchronized input has disagreed with the held level for DEBOUNCE_CYCLES.
module sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o
);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], d_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/fire_request_ctrl.sv
// Fire request front end: debounces the request, gates it with arm and magazine count,
// and issues one shoot pulse per accepted request followed by a shot + cooldown hold-off.
module fire_request_ctrl
    import fire_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SHOT_CYCLES     = SHOT_CYCLES_DEFAULT,
    parameter int unsigned COOLDOWN_CYCLES = 25000000,
    parameter int unsigned MAX_SHOTS       = 4,
    parameter int unsigned CNT_W           = 32
) (
    input  logic                clock,
    input  logic                resetn,
    fire_request_ctrl_if.slave  bus
);

    localparam logic [7:0]       MaxShots    = 8'(MAX_SHOTS);
    localparam logic [CNT_W-1:0] ShotLast    = CNT_W'(SHOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CooldownLast = CNT_W'(COOLDOWN_CYCLES - 1);

    logic [1:0]       arm_sync_q;
    logic             arm_s;
    logic             fire_level;
    logic             fire_rise;
    logic             accept;

    fire_state_e      state_q;
    logic [CNT_W-1:0] timer_q;
    logic [7:0]       shots_left_q;
    logic             shoot_pulse_q;
    logic             req_dropped_q;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_fire_db (
        .clk_i   (clock),
        .rst_ni  (resetn),
        .d_i     (bus.fire_req),
        .level_o (fire_level),
        .rise_o  (fire_rise)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            arm_sync_q <= 2'b00;
        end else begin
            arm_sync_q <= {arm_sync_q[0], bus.arm};
        end
    end

    assign arm_s  = arm_sync_q[1];
    assign accept = fire_rise & fire_level;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            shots_left_q  <= MaxShots;
            shoot_pulse_q <= 1'b0;
            req_dropped_q <= 1'b0;
        end else begin
            shoot_pulse_q <= 1'b0;
            req_dropped_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (arm_s && (shots_left_q != 8'd0)) begin
                            state_q       <= StFire;
                            shoot_pulse_q <= 1'b1;
                        end else begin
                            req_dropped_q <= 1'b1;
                        end
                    end
                end
                StFire: begin
                    timer_q      <= '0;
                    shots_left_q <= shots_left_q - 8'd1;
                    state_q      <= StShot;
                end
                StShot: begin
                    if (timer_q == ShotLast) begin
                        timer_q <= '0;
                        state_q <= StCooldown;
                    end else begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
                StCooldown: begin
                    if (timer_q == CooldownLast) begin
                        timer_q <= '0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + CNT_W'(1);
                    end
                end
            endcase
            // Requests never queue behind a shot in progress.
            if (accept && (state_q != StIdle)) begin
                req_dropped_q <= 1'b1;
            end
            // Reload overrides the FIRE decrement when both land in the same cycle.
            if (bus.reload) begin
                shots_left_q <= MaxShots;
            end
        end
    end

    assign bus.shoot_pulse = shoot_pulse_q;
    assign bus.req_dropped = req_dropped_q;
    assign bus.shots_left  = shots_left_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.ready       = (state_q == StIdle) && arm_s && (shots_left_q != 8'd0);

endmodule

// File: tb/tb_fire_request_ctrl.sv
// Directed bench for fire_request_ctrl with short timing overrides (debounce 4, shot 20,
// cooldown 10, magazine 2); all expectations are hand-derived cycle counts.
module tb_fire_request_ctrl;

    logic clock;
    logic resetn;

    int checks;
    int errors;
    int shoots_seen;
    int drops_seen;
    int busy_seen;

    fire_request_ctrl_if bus ();

    fire_request_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SHOT_CYCLES     (20),
        .COOLDOWN_CYCLES (10),
        .MAX_SHOTS       (2),
        .CNT_W           (32)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        shoots_seen = 0;
        drops_seen  = 0;
        busy_seen   = 0;
    endtask

    // Advance n cycles, sampling outputs 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (bus.shoot_pulse) shoots_seen++;
            if (bus.req_dropped) drops_seen++;
            if (bus.busy) busy_seen++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        checks       = 0;
        errors       = 0;
        bus.fire_req = 1'b0;
        bus.arm      = 1'b0;
        bus.reload   = 1'b0;
        resetn       = 1'b1;
        clear_counts();

        // Reset values
        #3 resetn = 1'b0;
        #2;
        check_eq("rst_shots_left", int'(bus.shots_left), 2);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_ready", int'(bus.ready), 0);
        check_eq("rst_shoot", int'(bus.shoot_pulse), 0);
        check_eq("rst_dropped", int'(bus.req_dropped), 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        bus.arm = 1'b1;
        step(3);
        check_eq("armed_ready", int'(bus.ready), 1);

        // 1: clean request, pulse 7 cycles after the edge, busy for 31 cycles
        clear_counts();
        bus.fire_req = 1'b1;
        step(6);
        check_eq("t1_no_early_pulse", shoots_seen, 0);
        step(1);
        check_eq("t1_pulse", int'(bus.shoot_pulse), 1);
        check_eq("t1_busy_in_fire", int'(bus.busy), 1);
        check_eq("t1_not_ready", int'(bus.ready), 0);
        step(1);
        check_eq("t1_shots_left", int'(bus.shots_left), 1);
        check_eq("t1_pulse_single", int'(bus.shoot_pulse), 0);
        clear_counts();
        step(29);
        check_eq("t1_busy_len", busy_seen, 29);
        check_eq("t1_no_second_pulse", shoots_seen, 0);
        step(1);
        check_eq("t1_busy_done", int'(bus.busy), 0);
        check_eq("t1_ready_again", int'(bus.ready), 1);
        bus.fire_req = 1'b0;
        clear_counts();
        step(10);
        check_eq("t1_release_shots", shoots_seen, 0);
        check_eq("t1_release_drops", drops_seen, 0);

        // 2: two-cycle glitch is rejected by the debounce
        clear_counts();
        bus.fire_req = 1'b1;
        step(2);
        bus.fire_req = 1'b0;
        step(12);
        check_eq("t2_glitch_shots", shoots_seen, 0);
        check_eq("t2_glitch_drops", drops_seen, 0);
        check_eq("t2_shots_left", int'(bus.shots_left), 1);

        // 3: second request accepted during SHOT is dropped
        clear_counts();
        bus.fire_req = 1'b1;
        step(7);
        check_eq("t3_pulse", int'(bus.shoot_pulse), 1);
        bus.fire_req = 1'b0;
        step(6);
        bus.fire_req = 1'b1;
        clear_counts();
        step(8);
        check_eq("t3_dropped", drops_seen, 1);
        check_eq("t3_no_retrigger", shoots_seen, 0);
        clear_counts();
        step(16);
        check_eq("t3_busy_rest", busy_seen, 16);
        step(1);
        check_eq("t3_idle", int'(bus.busy), 0);
        check_eq("t3_empty", int'(bus.shots_left), 0);
        check_eq("t3_empty_not_ready", int'(bus.ready), 0);

        // 4: empty magazine drops, reload restores; reload during FIRE wins
        bus.fire_req = 1'b0;
        step(8);
        clear_counts();
        bus.fire_req = 1'b1;
        step(10);
        check_eq("t4_empty_drop", drops_seen, 1);
        check_eq("t4_empty_no_shot", shoots_seen, 0);
        check_eq("t4_still_empty", int'(bus.shots_left), 0);
        bus.reload = 1'b1;
        step(1);
        bus.reload = 1'b0;
        check_eq("t4_reload_shots", int'(bus.shots_left), 2);
        check_eq("t4_reload_ready", int'(bus.ready), 1);
        bus.fire_req = 1'b0;
        step(8);
        bus.fire_req = 1'b1;
        clear_counts();
        step(7);
        check_eq("t4_fire_pulse", int'(bus.shoot_pulse), 1);
        bus.reload = 1'b1;
        step(1);
        bus.reload = 1'b0;
        check_eq("t4_reload_in_fire", int'(bus.shots_left), 2);
        step(30);
        check_eq("t4_done", int'(bus.busy), 0);
        check_eq("t4_ready", int'(bus.ready), 1);

        // 5: disarmed request dropped; disarm mid-SHOT lets the shot finish
        bus.arm      = 1'b0;
        bus.fire_req = 1'b0;
        step(8);
        check_eq("t5_disarmed_ready", int'(bus.ready), 0);
        clear_counts();
        bus.fire_req = 1'b1;
        step(10);
        check_eq("t5_disarmed_drop", drops_seen, 1);
        check_eq("t5_disarmed_no_shot", shoots_seen, 0);
        check_eq("t5_disarmed_not_busy", busy_seen, 0);
        bus.arm      = 1'b1;
        bus.fire_req = 1'b0;
        step(8);
        check_eq("t5_rearmed_ready", int'(bus.ready), 1);
        clear_counts();
        bus.fire_req = 1'b1;
        step(7);
        check_eq("t5_shot", shoots_seen, 1);
        step(5);
        bus.arm = 1'b0;
        clear_counts();
        step(26);
        check_eq("t5_sequence_completes", busy_seen, 25);
        check_eq("t5_idle", int'(bus.busy), 0);
        check_eq("t5_disarmed_after", int'(bus.ready), 0);
        check_eq("t5_shots_left", int'(bus.shots_left), 1);
        bus.arm = 1'b1;
        step(3);
        check_eq("t5_rearm_ready", int'(bus.ready), 1);

        // 6: reset during SHOT
        bus.fire_req = 1'b0;
        step(8);
        bus.fire_req = 1'b1;
        step(15);
        check_eq("t6_in_shot", int'(bus.busy), 1);
        #1;
        resetn       = 1'b0;
        bus.fire_req = 1'b0;
        #1;
        check_eq("t6_rst_shots_left", int'(bus.shots_left), 2);
        check_eq("t6_rst_busy", int'(bus.busy), 0);
        check_eq("t6_rst_ready", int'(bus.ready), 0);
        check_eq("t6_rst_shoot", int'(bus.shoot_pulse), 0);
        check_eq("t6_rst_dropped", int'(bus.req_dropped), 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        clear_counts();
        step(3);
        check_eq("t6_post_ready", int'(bus.ready), 1);
        check_eq("t6_post_busy", busy_seen, 0);
        check_eq("t6_post_no_pulse", shoots_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
